// File: rtl/fft_agu_sequencer_if.sv
// Handshake/bus bundle between the FFT controller and the AGU sequencer.
// The stall signal exists only when FFT_AGU_STALL_EN is defined.
// master: controller side (issues start/stall, observes sequencer outputs)
// slave : sequencer side
interface fft_agu_sequencer_if #(
  parameter int M = 9
);
  logic         start;
`ifdef FFT_AGU_STALL_EN
  logic         stall;
`endif
  logic [M-1:0] level;
  logic [M-1:0] index;
  logic         rd_valid;
  logic         rd_bank;
  logic         wr_en;
  logic [M-1:0] wr_level;
  logic [M-1:0] wr_index;
  logic         wr_bank;
  logic         busy;
  logic         done;

`ifdef FFT_AGU_STALL_EN
  modport master (
    output start, stall,
    input  level, index, rd_valid, rd_bank, wr_en, wr_level, wr_index, wr_bank, busy, done
  );
  modport slave (
    input  start, stall,
    output level, index, rd_valid, rd_bank, wr_en, wr_level, wr_index, wr_bank, busy, done
  );
`else
  modport master (
    output start,
    input  level, index, rd_valid, rd_bank, wr_en, wr_level, wr_index, wr_bank, busy, done
  );
  modport slave (
    input  start,
    output level, index, rd_valid, rd_bank, wr_en, wr_level, wr_index, wr_bank, busy, done
  );
`endif
endinterface

// File: rtl/fft_agu_sequencer.sv
// FFT address-generation sequencer: steps (level, index) butterfly counters,
// issues read strobes, replays them as write strobes BFLY_LAT cycles later,
// and inserts a BFLY_LAT-cycle drain gap between levels so that reads of the
// next level never overtake writes of the current one.
// Optional build macro: FFT_AGU_STALL_EN adds a stall input that freezes the
// whole sequencer (FSM, counters, write pipeline) outside IDLE.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start, outputs idle
// S_RUN   | one butterfly read per cycle, index counting up
// S_DRAIN | no reads, waiting for the level's writes to retire
// S_DONE  | one-cycle done pulse, then back to IDLE
module fft_agu_sequencer #(
  parameter int M        = 9,
  parameter int BFLY_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fft_agu_sequencer_if.slave   bus
);

  localparam logic [M-1:0] IDX_LAST = M'((2 ** (M - 1)) - 1);
  localparam logic [M-1:0] LVL_LAST = M'(M - 1);
  localparam logic [3:0]   DRAIN_LD = 4'(BFLY_LAT);
  localparam int           PW       = 2 * M + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [M-1:0]  level_q;
  logic [M-1:0]  index_q;
  logic [3:0]    drain_q;
  logic          rd_valid_q;
  logic          busy_q;
  logic          done_q;
  logic [PW-1:0] pipe_q [BFLY_LAT];
  logic          freeze;
  logic          wr_valid;

  // Stall only bites once a transform is under way; IDLE must still see start.
`ifdef FFT_AGU_STALL_EN
  assign freeze = bus.stall && (state_q != S_IDLE);
`else
  assign freeze = 1'b0;
`endif

  // Sequencer FSM with registered counters and strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      level_q    <= '0;
      index_q    <= '0;
      drain_q    <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (!freeze) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q    <= S_RUN;
            level_q    <= '0;
            index_q    <= '0;
            rd_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          if (index_q == IDX_LAST) begin
            index_q    <= '0;
            drain_q    <= DRAIN_LD;
            rd_valid_q <= 1'b0;
            state_q    <= S_DRAIN;
          end else begin
            index_q <= index_q + M'(1);
          end
        end
        S_DRAIN: begin
          // The counter value 1 marks the cycle the level's last write lands.
          if (drain_q == 4'd1) begin
            drain_q <= '0;
            if (level_q == LVL_LAST) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              level_q    <= level_q + M'(1);
              rd_valid_q <= 1'b1;
              state_q    <= S_RUN;
            end
          end else begin
            drain_q <= drain_q - 4'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          level_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write-delay line: replays {rd_valid, level, index} BFLY_LAT cycles later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BFLY_LAT; i++) pipe_q[i] <= '0;
    end else if (!freeze) begin
      pipe_q[0] <= {rd_valid_q, level_q, index_q};
      for (int i = 1; i < BFLY_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign wr_valid     = pipe_q[BFLY_LAT-1][PW-1];

  assign bus.level    = level_q;
  assign bus.index    = index_q;
  assign bus.rd_valid = rd_valid_q & ~freeze;
  assign bus.rd_bank  = level_q[0];
  assign bus.wr_en    = wr_valid & ~freeze;
  assign bus.wr_level = pipe_q[BFLY_LAT-1][PW-2:M];
  assign bus.wr_index = pipe_q[BFLY_LAT-1][M-1:0];
  // Qualified by the write strobe so the bank select idles at 0 (incl. reset).
  assign bus.wr_bank  = wr_valid & ~pipe_q[BFLY_LAT-1][M];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_fft_agu_sequencer.sv
// Directed self-checking bench for fft_agu_sequencer (M=3 and M=9, BFLY_LAT=2).
module tb_fft_agu_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fft_agu_sequencer_if #(.M(3)) if3 ();
  fft_agu_sequencer_if #(.M(9)) if9 ();

  fft_agu_sequencer #(.M(3), .BFLY_LAT(2)) dut3 (.clk(clk), .reset_n(reset_n), .bus(if3.slave));
  fft_agu_sequencer #(.M(9), .BFLY_LAT(2)) dut9 (.clk(clk), .reset_n(reset_n), .bus(if9.slave));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs3();
    return {14'd0, if3.level, if3.index, if3.wr_level, if3.wr_index,
            if3.rd_valid, if3.rd_bank, if3.wr_en, if3.wr_bank, if3.busy, if3.done};
  endfunction

  // One M=3 transform from IDLE. Model: each level is 4 read cycles + 2 drain
  // cycles (period 6); writes trail reads by 2; done at effective cycle 19.
  // Optional extra start pulses (cycles sa/sb) and a stall window st_lo..st_hi.
  task automatic run3(input int sa, input int sb, input int st_lo, input int st_hi);
    int reads, writes, dones, stl, e, k, wk;
    bit stalled, exp_rd, exp_wr;
    reads = 0; writes = 0; dones = 0; stl = 0;
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      stalled = (c >= st_lo) && (c <= st_hi);
`ifdef FFT_AGU_STALL_EN
      if3.stall = stalled;
`endif
      #1;
      e  = c - stl;
      k  = e - 1;
      wk = e - 3;
      exp_rd = !stalled && (e >= 1) && (e <= 18) && ((k % 6) < 4);
      exp_wr = !stalled && (wk >= 0) && (wk < 18) && ((wk % 6) < 4);
      reads  += int'(if3.rd_valid);
      writes += int'(if3.wr_en);
      dones  += int'(if3.done);
      check_val("rd_valid", 32'(if3.rd_valid), 32'(exp_rd));
      if (exp_rd) begin
        check_val("level", 32'(if3.level), 32'(k / 6));
        check_val("index", 32'(if3.index), 32'(k % 6));
        check_val("rd_bank", 32'(if3.rd_bank), 32'((k / 6) % 2));
      end
      check_val("wr_en", 32'(if3.wr_en), 32'(exp_wr));
      if (exp_wr) begin
        check_val("wr_level", 32'(if3.wr_level), 32'(wk / 6));
        check_val("wr_index", 32'(if3.wr_index), 32'(wk % 6));
        check_val("wr_bank", 32'(if3.wr_bank), 32'(1 - ((wk / 6) % 2)));
      end
      check_val("done", 32'(if3.done), 32'(!stalled && e == 19));
      check_val("busy", 32'(if3.busy), 32'(e >= 1 && e <= 19));
      if3.start = (c == sa) || (c == sb);
      if (stalled) stl++;
      @(negedge clk);
    end
    if3.start = 1'b0;
`ifdef FFT_AGU_STALL_EN
    if3.stall = 1'b0;
`endif
    check_val("reads_total", 32'(reads), 32'd12);
    check_val("writes_total", 32'(writes), 32'd12);
    check_val("done_count", 32'(dones), 32'd1);
  endtask

  initial begin
    int r, w, d, dc, bad;
    if3.start = 1'b0;
    if9.start = 1'b0;
`ifdef FFT_AGU_STALL_EN
    if3.stall = 1'b0;
    if9.stall = 1'b0;
`endif
    #2;
    check_val("reset_outs", outs3(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_val("reset_outs_clocked", outs3(), 32'd0);
    check_val("reset_busy9", 32'(if9.busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic run, reads and writes.
    run3(0, 0, 0, -1);
    // start pulses in a DRAIN cycle and in the DONE cycle are ignored.
    run3(5, 19, 0, -1);

    // Reset mid-transform (cycle 8, a level-1 read).
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (7) @(negedge clk);
    check_val("pre_reset_rd", 32'(if3.rd_valid), 32'd1);
    check_val("pre_reset_level", 32'(if3.level), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("abort_outs", outs3(), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bad += int'(if3.wr_en) + int'(if3.rd_valid) + int'(if3.busy);
    end
    check_val("post_abort_quiet", 32'(bad), 32'd0);
    run3(0, 0, 0, -1);

`ifdef FFT_AGU_STALL_EN
    run3(0, 0, 3, 5);
`endif

    // Full-size run, M=9.
    r = 0; w = 0; d = 0; dc = 0;
    if9.start = 1'b1;
    @(negedge clk);
    if9.start = 1'b0;
    for (int c = 1; c <= 2330; c++) begin
      if (c == 1) begin
        check_val("m9_first_rd", 32'(if9.rd_valid), 32'd1);
        check_val("m9_first_lvl_idx", 32'({if9.level, if9.index}), 32'd0);
      end
      r += int'(if9.rd_valid);
      w += int'(if9.wr_en);
      if (if9.done) begin
        d++;
        dc = c;
      end
      @(negedge clk);
    end
    check_val("m9_reads", 32'(r), 32'd2304);
    check_val("m9_writes", 32'(w), 32'd2304);
    check_val("m9_done_cycle", 32'(dc), 32'd2323);
    check_val("m9_done_count", 32'(d), 32'd1);
    check_val("m9_busy_end", 32'(if9.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
